// File: rtl/text_ram_write_arbiter.sv
// Round-robin arbiter for the character RAM write port, with a built-in full-screen clear engine.
// Optional feature: define TRAM_BOUNDS_CHECK_EN to drop (but still grant) requests with addr >= CELLS.
module text_ram_write_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int CELLS  = 2100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     clear_start,
  input  logic [DATA_W-1:0]        clear_fill,
  output logic                     clear_busy,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_data,
  output logic                     ram_wren,
  output logic                     oob_err
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;

  state_t              state_q, state_n;
  logic [PTR_W-1:0]    rr_ptr, rr_n;
  logic [ADDR_W-1:0]   clr_cnt, cnt_n;
  logic [DATA_W-1:0]   fill_q, fill_n;
  logic [NREQ-1:0]     gnt_n;
  logic                wren_n, busy_n, oob_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   data_n;

  logic [NREQ-1:0]     elig;
  logic                pick_valid;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    idx_p;
  int                  idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_oob;

  // The requester granted this cycle still holds req; masking it prevents a stale second grant.
  always_comb begin
    elig       = req & ~gnt;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_p      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_p = PTR_W'(idx);
      if (!pick_valid && elig[idx_p]) begin
        pick_valid = 1'b1;
        pick_idx   = idx_p;
      end
    end
  end

  assign sel_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[pick_idx*DATA_W +: DATA_W];

`ifdef TRAM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] CELLS_X = (ADDR_W+1)'(CELLS);
  assign sel_oob = ({1'b0, sel_addr} >= CELLS_X);
`else
  assign sel_oob = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    rr_n    = rr_ptr;
    cnt_n   = clr_cnt;
    fill_n  = fill_q;
    gnt_n   = '0;
    wren_n  = 1'b0;
    busy_n  = 1'b0;
    oob_n   = 1'b0;
    addr_n  = ram_addr;
    data_n  = ram_data;
    case (state_q)
      IDLE, GRANT: begin
        if (clear_start) begin
          state_n = CLEAR;
          busy_n  = 1'b1;
          wren_n  = 1'b1;
          addr_n  = '0;
          data_n  = clear_fill;
          fill_n  = clear_fill;
          cnt_n   = '0;
        end else if (en && pick_valid) begin
          state_n         = GRANT;
          gnt_n[pick_idx] = 1'b1;
          wren_n          = ~sel_oob;
          oob_n           = sel_oob;
          addr_n          = sel_addr;
          data_n          = sel_data;
          rr_n            = (pick_idx == PTR_W'(NREQ-1)) ? '0 : pick_idx + 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      CLEAR: begin
        // Cell 0 was written on entry, so the count names the cell currently on the port.
        if (clr_cnt == ADDR_W'(CELLS-1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          busy_n = 1'b1;
          wren_n = 1'b1;
          cnt_n  = clr_cnt + 1'b1;
          addr_n = clr_cnt + 1'b1;
          data_n = fill_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      clr_cnt    <= '0;
      fill_q     <= '0;
      gnt        <= '0;
      ram_wren   <= 1'b0;
      clear_busy <= 1'b0;
      oob_err    <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
    end else begin
      rr_ptr     <= rr_n;
      clr_cnt    <= cnt_n;
      fill_q     <= fill_n;
      gnt        <= gnt_n;
      ram_wren   <= wren_n;
      clear_busy <= busy_n;
      oob_err    <= oob_n;
      ram_addr   <= addr_n;
      ram_data   <= data_n;
    end
  end

endmodule

// File: tb/tb_text_ram_write_arbiter.sv
// Scoreboard bench for text_ram_write_arbiter: hand-computed expected writes are queued by the
// stimulus and popped by a negedge monitor whenever the DUT issues gnt, ram_wren or oob_err.
module tb_text_ram_write_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int CELLS  = 2100;
  localparam int W      = NREQ + 2 + ADDR_W + DATA_W;

  logic                   clk;
  logic                   reset;
  logic                   en;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   clear_start;
  logic [DATA_W-1:0]      clear_fill;
  logic                   clear_busy;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_data;
  logic                   ram_wren;
  logic                   oob_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  text_ram_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELLS(CELLS)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .clear_start(clear_start), .clear_fill(clear_fill), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .oob_err(oob_err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic push_exp(input logic [NREQ-1:0] g, input logic w, input logic o,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({g, w, o, a, d});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor / scoreboard
  logic [W-1:0] act_item;
  logic [W-1:0] exp_item;
  always @(negedge clk) begin
    if (!reset && (ram_wren || (|gnt) || oob_err)) begin
      act_item = {gnt, ram_wren, oob_err, ram_addr, ram_data};
      if (ram_wren) check("wren_needs_gnt_or_busy", 32'((|gnt) || clear_busy), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(act_item), 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        check("scoreboard_item", 32'(act_item), 32'(exp_item));
      end
    end
  end

  initial begin
    int cnt;
    reset = 1'b1; en = 1'b1; req = '0; req_addr = '0; req_data = '0;
    clear_start = 1'b0; clear_fill = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(10 + i), DATA_W'(8'h41 + i));

    // 1: reset with every request raised
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {26'd0, gnt, ram_wren, clear_busy, oob_err}, 32'd0);
    end
    push_exp(4'b0001, 1'b1, 1'b0, 12'd10, 8'h41);
    reset = 1'b0;
    @(negedge clk);
    check("first_gnt_req0", 32'(gnt), 32'b0001);
    req = '0;
    tick(2);

    // 2: lone requester, held one extra cycle after its grant
    set_req(2, 12'd61, 8'h53);
    push_exp(4'b0100, 1'b1, 1'b0, 12'd61, 8'h53);
    req = 4'b0100;
    @(negedge clk);
    check("lone_gnt_latency", 32'(gnt), 32'b0100);
    @(negedge clk);
    check("no_double_gnt", 32'({gnt, ram_wren}), 32'd0);
    req = '0;
    tick(2);

    // 3: round robin over 4'b1011 from rr_ptr=0
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      push_exp(4'b0001, 1'b1, 1'b0, 12'd10, 8'h41);
      push_exp(4'b0010, 1'b1, 1'b0, 12'd11, 8'h42);
      push_exp(4'b1000, 1'b1, 1'b0, 12'd13, 8'h44);
    end
    req = 4'b1011;
    tick(6);
    req = '0;
    tick(2);

    // 4: clear with a pending request and an ignored restart
    set_req(1, 12'h077, 8'h31);
    for (int a = 0; a < CELLS; a++) push_exp(4'b0000, 1'b1, 1'b0, ADDR_W'(a), 8'h00);
    push_exp(4'b0010, 1'b1, 1'b0, 12'h077, 8'h31);
    req = 4'b0010;
    clear_fill = 8'h00;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    cnt = 0;
    while (clear_busy && cnt < 3000) begin
      cnt++;
      if (cnt == 5) begin clear_start = 1'b1; clear_fill = 8'hFF; end
      if (cnt == 6) begin clear_start = 1'b0; clear_fill = 8'h00; end
      @(negedge clk);
    end
    check("clear_busy_cycles", 32'(cnt), 32'(CELLS));
    check("no_gnt_when_busy_falls", 32'(gnt), 32'd0);
    @(negedge clk);
    check("gnt_after_clear", 32'(gnt), 32'b0010);
    req = '0;
    tick(2);

    // 5: en held low with a pending request
    set_req(0, 12'd5, 8'h45);
    en = 1'b0;
    req = 4'b0001;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt != 0 || ram_wren) cnt++;
    end
    check("en_low_no_activity", 32'(cnt), 32'd0);
    push_exp(4'b0001, 1'b1, 1'b0, 12'd5, 8'h45);
    en = 1'b1;
    @(negedge clk);
    check("gnt_after_en", 32'(gnt), 32'b0001);
    req = '0;
    tick(2);

    // 6: last valid cell, then the first out-of-range cell
    set_req(3, 12'd2099, 8'h5A);
    push_exp(4'b1000, 1'b1, 1'b0, 12'd2099, 8'h5A);
    req = 4'b1000;
    @(negedge clk);
    check("last_cell_wren", 32'({gnt, ram_wren}), 32'b10001);
    req = '0;
    tick(2);
    set_req(3, 12'd2100, 8'h5B);
`ifdef TRAM_BOUNDS_CHECK_EN
    push_exp(4'b1000, 1'b0, 1'b1, 12'd2100, 8'h5B);
`else
    push_exp(4'b1000, 1'b1, 1'b0, 12'd2100, 8'h5B);
`endif
    req = 4'b1000;
    @(negedge clk);
`ifdef TRAM_BOUNDS_CHECK_EN
    check("oob_gnt_wren_err", 32'({gnt, ram_wren, oob_err}), 32'b100001);
`else
    check("oob_gnt_wren_err", 32'({gnt, ram_wren, oob_err}), 32'b100010);
`endif
    req = '0;
    @(negedge clk);
    check("oob_err_one_cycle", 32'(oob_err), 32'd0);
    tick(1);

    // Reset in the middle of a clear
    for (int a = 0; a < 3; a++) push_exp(4'b0000, 1'b1, 1'b0, ADDR_W'(a), 8'h2E);
    clear_fill = 8'h2E;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    tick(2);
    #2 reset = 1'b1;
    #1 check("async_reset_mid_clear", {7'd0, clear_busy, ram_wren, ram_addr, 12'd0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (clear_busy || ram_wren) cnt++;
    end
    check("clear_not_resumed", 32'(cnt), 32'd0);

    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
